eth_deframer: RTL and testbench

//   Receive-side counterpart of eth_framer. Takes received Ethernet frames as an 8-bit AXIS

---
 rtl/eth_pkg.sv | 17 +
 rtl/eth_deframer_axis_reg.sv | 46 ++++
 rtl/eth_deframer.sv | 158 +++++++++++++++
 tb/tb_eth_deframer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_pkg
//  Purpose  : Shared Ethernet types and constants for the receive deframer.
//  Revision : 1.0 - initial release
// ============================================================================
package eth_pkg;

    typedef logic [47:0] mac_t;
    typedef logic [15:0] ethertype_t;

    // dst MAC (6) + src MAC (6) + ethertype (2)
    localparam int   HDR_BYTES = 14;
    localparam mac_t BCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage
`default_nettype wire

// File: rtl/eth_deframer_axis_reg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_reg
//  Purpose  : One-stage AXIS register slice (8-bit data + tlast). Accepts a new
//             beat whenever empty or being drained in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [7:0] i_in_data,
    input  logic       i_in_last,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_out_data,
    output logic       o_out_last
);

    logic       r_valid;
    logic [7:0] r_data;
    logic       r_last;

    assign o_in_ready  = !r_valid || i_out_ready;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    assign o_out_last  = r_last;

    // Load on an input beat; otherwise empty the slice once its beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_last  <= 1'b0;
        end else if (i_in_valid && o_in_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_in_data;
            r_last  <= i_in_last;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : eth_deframer
//  Purpose  : Parses dst/src MAC and ethertype from a received byte stream,
//             filters on address/ethertype and forwards the payload (FCS
//             included) through a register slice. Saturating frame counters.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_deframer
    import eth_pkg::*;
#(
    parameter bit          ACCEPT_BCAST     = 1'b1,
    parameter logic [15:0] ETHERTYPE_FILTER = 16'h0000,
    parameter int          CNT_W            = 16
) (
    input  logic             clk,
    input  logic             sreset,
    input  logic [47:0]      our_mac,
    input  logic             promisc,
    output logic             in_axis_tready,
    input  logic             in_axis_tvalid,
    input  logic             in_axis_tlast,
    input  logic [7:0]       in_axis_tdata,
    input  logic             out_axis_tready,
    output logic             out_axis_tvalid,
    output logic             out_axis_tlast,
    output logic [7:0]       out_axis_tdata,
    output logic [47:0]      out_dst_mac,
    output logic [47:0]      out_src_mac,
    output logic [15:0]      out_ethertype,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_dropped
);

    localparam logic [1:0] c_ST_HEADER  = 2'd0;
    localparam logic [1:0] c_ST_PAYLOAD = 2'd1;
    localparam logic [1:0] c_ST_DROP    = 2'd2;
    localparam logic [3:0] c_LAST_IDX   = 4'(HDR_BYTES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_count;
    // First 13 header bytes; the 14th is taken straight from the bus.
    logic [103:0]     r_hdr;

    logic             w_in_beat;
    logic             w_hdr_beat;
    logic             w_runt;
    logic             w_hdr_done;
    logic             w_pass;
    logic             w_accept;
    logic             w_filt_drop;
    logic             w_frame_done;
    logic [111:0]     w_hdr_full;
    mac_t             w_dst;
    mac_t             w_src;
    ethertype_t       w_type;
    logic             w_slice_in_valid;
    logic             w_slice_in_ready;

    assign w_in_beat    = in_axis_tvalid && in_axis_tready;
    assign w_hdr_beat   = w_in_beat && (r_state == c_ST_HEADER);
    assign w_hdr_full   = {r_hdr, in_axis_tdata};
    assign w_dst        = w_hdr_full[111:64];
    assign w_src        = w_hdr_full[63:16];
    assign w_type       = w_hdr_full[15:0];

    // A tlast anywhere in the header (including the 14th byte) leaves no payload.
    assign w_runt       = w_hdr_beat && in_axis_tlast;
    assign w_hdr_done   = w_hdr_beat && !in_axis_tlast && (r_count == c_LAST_IDX);
    assign w_pass       = ((w_dst == our_mac) || promisc || (ACCEPT_BCAST && (w_dst == BCAST_MAC)))
                          && ((ETHERTYPE_FILTER == 16'h0000) || (w_type == ETHERTYPE_FILTER));
    assign w_accept     = w_hdr_done && w_pass;
    assign w_filt_drop  = w_hdr_done && !w_pass;
    assign w_frame_done = w_in_beat && in_axis_tlast && (r_state == c_ST_PAYLOAD);

    // State register.
    always_ff @(posedge clk) begin
        if (sreset) r_state <= c_ST_HEADER;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_HEADER: begin
                if (w_accept)         w_state_nxt = c_ST_PAYLOAD;
                else if (w_filt_drop) w_state_nxt = c_ST_DROP;
            end
            c_ST_PAYLOAD: if (w_frame_done) w_state_nxt = c_ST_HEADER;
            c_ST_DROP:    if (w_in_beat && in_axis_tlast) w_state_nxt = c_ST_HEADER;
            default:      w_state_nxt = c_ST_HEADER;
        endcase
    end

    // Per-state handshake outputs; only payload bytes enter the slice.
    always_comb begin
        in_axis_tready   = 1'b1;
        w_slice_in_valid = 1'b0;
        if (r_state == c_ST_PAYLOAD) begin
            in_axis_tready   = w_slice_in_ready;
            w_slice_in_valid = in_axis_tvalid;
        end
    end

    // Header byte counter and shift register.
    always_ff @(posedge clk) begin
        if (sreset) begin
            r_count <= 4'd0;
            r_hdr   <= '0;
        end else if (w_hdr_beat) begin
            r_hdr   <= w_hdr_full[103:0];
            r_count <= (in_axis_tlast || (r_count == c_LAST_IDX)) ? 4'd0 : r_count + 4'd1;
        end
    end

    // Header outputs update only when a frame is accepted.
    always_ff @(posedge clk) begin
        if (sreset) begin
            out_dst_mac   <= '0;
            out_src_mac   <= '0;
            out_ethertype <= '0;
        end else if (w_accept) begin
            out_dst_mac   <= w_dst;
            out_src_mac   <= w_src;
            out_ethertype <= w_type;
        end
    end

    // Saturating frame counters; runt and filter drop are mutually exclusive.
    always_ff @(posedge clk) begin
        if (sreset) begin
            frames_ok      <= '0;
            frames_dropped <= '0;
        end else begin
            if (w_frame_done && (frames_ok != '1))
                frames_ok <= frames_ok + 1'b1;
            if ((w_runt || w_filt_drop) && (frames_dropped != '1))
                frames_dropped <= frames_dropped + 1'b1;
        end
    end

    axis_reg u_slice (
        .clk         (clk),
        .rst         (sreset),
        .i_in_valid  (w_slice_in_valid),
        .o_in_ready  (w_slice_in_ready),
        .i_in_data   (in_axis_tdata),
        .i_in_last   (in_axis_tlast),
        .o_out_valid (out_axis_tvalid),
        .i_out_ready (out_axis_tready),
        .o_out_data  (out_axis_tdata),
        .o_out_last  (out_axis_tlast)
    );

endmodule
`default_nettype wire

// File: tb/tb_eth_deframer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_eth_deframer
//  Purpose  : Directed self-checking bench for eth_deframer. Three instances
//             cover default, ACCEPT_BCAST=0 and ETHERTYPE_FILTER=88B5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_eth_deframer;

    logic        clk = 1'b0;
    logic        sreset = 1'b1;
    logic [47:0] our_mac = 48'h0001_0203_0405;
    logic        promisc = 1'b0;
    logic        in_tvalid = 1'b0;
    logic        in_tlast = 1'b0;
    logic [7:0]  in_tdata = 8'h00;
    logic        out_tready = 1'b1;
    int          sel = 0;
    int          mode = 0;

    logic        tv_v     [3];
    logic        tready_v [3];
    logic        otvalid_v[3];
    logic        otlast_v [3];
    logic [7:0]  otdata_v [3];
    logic [47:0] dst_v    [3];
    logic [47:0] src_v    [3];
    logic [15:0] type_v   [3];
    logic [15:0] ok_v     [3];
    logic [15:0] drop_v   [3];

    logic        w_tready, w_otvalid, w_otlast;
    logic [7:0]  w_otdata;

    int          total = 0;
    int          bad = 0;
    int          hdr_stalls = 0;
    int          all_stalls = 0;
    int          n_valid = 0;
    int          cap_rd = 0;
    logic [8:0]  cap[$];
    logic [8:0]  exp_q[$];
    logic [7:0]  pl[$];

    always #5 clk = ~clk;

    assign tv_v[0] = in_tvalid && (sel == 0);
    assign tv_v[1] = in_tvalid && (sel == 1);
    assign tv_v[2] = in_tvalid && (sel == 2);
    assign w_tready  = tready_v[sel];
    assign w_otvalid = otvalid_v[sel];
    assign w_otlast  = otlast_v[sel];
    assign w_otdata  = otdata_v[sel];

    eth_deframer u_dut0 (
        .clk(clk), .sreset(sreset), .our_mac(our_mac), .promisc(promisc),
        .in_axis_tready(tready_v[0]), .in_axis_tvalid(tv_v[0]), .in_axis_tlast(in_tlast),
        .in_axis_tdata(in_tdata), .out_axis_tready(out_tready), .out_axis_tvalid(otvalid_v[0]),
        .out_axis_tlast(otlast_v[0]), .out_axis_tdata(otdata_v[0]), .out_dst_mac(dst_v[0]),
        .out_src_mac(src_v[0]), .out_ethertype(type_v[0]), .frames_ok(ok_v[0]),
        .frames_dropped(drop_v[0])
    );

    eth_deframer #(.ACCEPT_BCAST(1'b0)) u_dut1 (
        .clk(clk), .sreset(sreset), .our_mac(our_mac), .promisc(promisc),
        .in_axis_tready(tready_v[1]), .in_axis_tvalid(tv_v[1]), .in_axis_tlast(in_tlast),
        .in_axis_tdata(in_tdata), .out_axis_tready(out_tready), .out_axis_tvalid(otvalid_v[1]),
        .out_axis_tlast(otlast_v[1]), .out_axis_tdata(otdata_v[1]), .out_dst_mac(dst_v[1]),
        .out_src_mac(src_v[1]), .out_ethertype(type_v[1]), .frames_ok(ok_v[1]),
        .frames_dropped(drop_v[1])
    );

    eth_deframer #(.ETHERTYPE_FILTER(16'h88B5)) u_dut2 (
        .clk(clk), .sreset(sreset), .our_mac(our_mac), .promisc(promisc),
        .in_axis_tready(tready_v[2]), .in_axis_tvalid(tv_v[2]), .in_axis_tlast(in_tlast),
        .in_axis_tdata(in_tdata), .out_axis_tready(out_tready), .out_axis_tvalid(otvalid_v[2]),
        .out_axis_tlast(otlast_v[2]), .out_axis_tdata(otdata_v[2]), .out_dst_mac(dst_v[2]),
        .out_src_mac(src_v[2]), .out_ethertype(type_v[2]), .frames_ok(ok_v[2]),
        .frames_dropped(drop_v[2])
    );

    // Record every output beat of the selected instance and count valid cycles.
    always @(posedge clk) begin
        if (!sreset && w_otvalid && out_tready) cap.push_back({w_otlast, w_otdata});
        if (w_otvalid) n_valid <= n_valid + 1;
    end

    // Downstream ready pattern: 0 = always ready, 1 = toggle, 2 = held low.
    initial begin
        forever begin
            @(negedge clk);
            case (mode)
                0:       out_tready = 1'b1;
                1:       out_tready = !out_tready;
                default: out_tready = 1'b0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer one byte from a negedge and hold it until it is taken.
    task automatic send_byte(input logic [7:0] d, input logic l, input bit is_hdr);
        int n;
        n = 0;
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tlast  = l;
        #1;
        if (!w_tready) begin
            all_stalls++;
            if (is_hdr) hdr_stalls++;
        end
        while (!w_tready) begin
            @(negedge clk);
            #1;
            n++;
            if (n > 500) begin
                check("in_tready_timeout", {63'd0, w_tready}, 64'd1);
                break;
            end
        end
        @(negedge clk);
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
    endtask

    // Header then the bytes in pl; tlast on the final byte sent.
    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] ty, input bit expect_out);
        logic [111:0] hdr;
        hdr = {dst, src, ty};
        for (int i = 0; i < 14; i++)
            send_byte(hdr[111 - 8*i -: 8], (i == 13) && (pl.size() == 0), 1'b1);
        for (int i = 0; i < pl.size(); i++) begin
            send_byte(pl[i], i == pl.size() - 1, 1'b0);
            if (expect_out) exp_q.push_back({i == pl.size() - 1, pl[i]});
        end
    endtask

    task automatic drain();
        repeat (40) @(negedge clk);
    endtask

    task automatic check_out(input string tag);
        int n;
        n = cap.size() - cap_rd;
        check({tag, "_count"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), cap[cap_rd + i], exp_q[i]);
        cap_rd = cap.size();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        sreset = 1'b0;
        #1;
        // Reset state.
        check("rst_in_tready", {63'd0, w_tready}, 64'd1);
        check("rst_out_tvalid", {63'd0, w_otvalid}, 64'd0);
        check("rst_ok", ok_v[0], 0);
        check("rst_dropped", drop_v[0], 0);
        check("rst_ethertype", type_v[0], 0);
        @(negedge clk);

        // Unicast frame to our MAC.
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hCA, 8'hFE};
        send_frame(48'h0001_0203_0405, 48'h0A0B_0C0D_0E0F, 16'h88B5, 1'b1);
        drain();
        check_out("uc");
        check("uc_type", type_v[0], 16'h88B5);
        check("uc_src", src_v[0], 48'h0A0B_0C0D_0E0F);
        check("uc_dst", dst_v[0], 48'h0001_0203_0405);
        check("uc_ok", ok_v[0], 1);
        check("uc_dropped", drop_v[0], 0);

        // Broadcast accepted with ACCEPT_BCAST=1.
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(48'hFFFF_FFFF_FFFF, 48'h0A0B_0C0D_0E0F, 16'h0800, 1'b1);
        drain();
        check_out("bc");
        check("bc_ok", ok_v[0], 2);
        check("bc_dst", dst_v[0], 48'hFFFF_FFFF_FFFF);

        // Promiscuous mode accepts a foreign MAC.
        promisc = 1'b1;
        pl = '{8'h55, 8'h66, 8'h77};
        send_frame(48'h1122_3344_5566, 48'h0A0B_0C0D_0E0F, 16'h0806, 1'b1);
        drain();
        promisc = 1'b0;
        check_out("pm");
        check("pm_ok", ok_v[0], 3);
        check("pm_type", type_v[0], 16'h0806);

        // Foreign MAC without promisc is dropped, header outputs hold.
        pl = '{8'h99, 8'h98};
        send_frame(48'h1122_3344_5566, 48'h0A0B_0C0D_0E0F, 16'h0800, 1'b0);
        drain();
        check_out("fm");
        check("fm_dropped", drop_v[0], 1);
        check("fm_type_hold", type_v[0], 16'h0806);

        // 10-byte runt, then a good frame.
        for (int i = 0; i < 10; i++) send_byte(8'(i), i == 9, 1'b1);
        drain();
        check_out("runt");
        check("runt_dropped", drop_v[0], 2);
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hCA, 8'hFE};
        send_frame(48'h0001_0203_0405, 48'h0A0B_0C0D_0E0F, 16'h88B5, 1'b1);
        drain();
        check_out("after_runt");
        check("after_runt_ok", ok_v[0], 4);

        // Header-only frame (tlast on the 14th byte).
        pl.delete();
        send_frame(48'h0001_0203_0405, 48'h0A0B_0C0D_0E0F, 16'h88B5, 1'b0);
        drain();
        check_out("zlen");
        check("zlen_dropped", drop_v[0], 3);
        check("zlen_ok", ok_v[0], 4);

        // Toggling ready with a 20-cycle stall, back-to-back frames.
        hdr_stalls = 0;
        mode = 1;
        fork
            begin
                pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                       8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C};
                send_frame(48'h0001_0203_0405, 48'h0A0B_0C0D_0E0F, 16'h88B5, 1'b1);
                pl = '{8'hA1, 8'hA2, 8'hA3};
                send_frame(48'h0001_0203_0405, 48'h0A0B_0C0D_0E0F, 16'h1234, 1'b1);
            end
            begin
                for (int k = 0; k < 500 && (cap.size() - cap_rd) < 3; k++) @(negedge clk);
                mode = 2;
                repeat (5) @(negedge clk);
                #2;
                check("stall_in_tready", {63'd0, w_tready}, 64'd0);
                check("stall_out_tvalid", {63'd0, w_otvalid}, 64'd1);
                repeat (15) @(negedge clk);
                mode = 1;
            end
        join
        drain();
        mode = 0;
        @(negedge clk);
        check_out("bp");
        check("bp_hdr_stalls", hdr_stalls, 0);
        check("bp_ok", ok_v[0], 6);
        check("bp_type", type_v[0], 16'h1234);

        // ACCEPT_BCAST=0 instance drops broadcast.
        sel = 1;
        n_valid = 0;
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(48'hFFFF_FFFF_FFFF, 48'h0A0B_0C0D_0E0F, 16'h0800, 1'b0);
        drain();
        check_out("nobc");
        check("nobc_valid_cycles", n_valid, 0);
        check("nobc_dropped", drop_v[1], 1);
        check("nobc_ok", ok_v[1], 0);

        // Ethertype filter instance.
        sel = 2;
        all_stalls = 0;
        pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(48'h0001_0203_0405, 48'h0A0B_0C0D_0E0F, 16'h0800, 1'b0);
        drain();
        check_out("ef_drop");
        check("ef_stalls", all_stalls, 0);
        check("ef_dropped", drop_v[2], 1);
        pl = '{8'hDE, 8'hAD};
        send_frame(48'h0001_0203_0405, 48'h0A0B_0C0D_0E0F, 16'h88B5, 1'b1);
        drain();
        check_out("ef_pass");
        check("ef_ok", ok_v[2], 1);

        // Reset in the middle of a payload.
        sel = 0;
        begin
            logic [111:0] hdr;
            hdr = {48'h0001_0203_0405, 48'h0A0B_0C0D_0E0F, 16'h88B5};
            for (int i = 0; i < 14; i++) send_byte(hdr[111 - 8*i -: 8], 1'b0, 1'b1);
            for (int i = 0; i < 3; i++) send_byte(8'hC0 + 8'(i), 1'b0, 1'b0);
        end
        sreset = 1'b1;
        @(negedge clk);
        sreset = 1'b0;
        #1;
        check("sr_out_tvalid", {63'd0, w_otvalid}, 64'd0);
        check("sr_ok", ok_v[0], 0);
        check("sr_dropped", drop_v[0], 0);
        check("sr_type", type_v[0], 0);
        @(negedge clk);
        cap_rd = cap.size();
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hCA, 8'hFE};
        send_frame(48'h0001_0203_0405, 48'h0A0B_0C0D_0E0F, 16'h88B5, 1'b1);
        drain();
        check_out("sr_next");
        check("sr_next_ok", ok_v[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
